// File: rtl/constraint_eval_pipe.sv
// Two-stage constraint evaluator: per-channel predicates over A/B operands,
// AND-reduced into a satisfied flag, with runtime channel config and stats.
module constraint_eval_pipe #(
    parameter int NUM_CH = 5,
    parameter int W      = 8,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_CH*W-1:0]        in_a,
    input  logic [NUM_CH*W-1:0]        in_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_sat,
    output logic [NUM_CH-1:0]          out_mask,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_CH)-1:0]  cfg_idx,
    input  logic [2:0]                 cfg_op,
    input  logic [W-1:0]               cfg_k,
    input  logic [W:0]                 cfg_c,
    output logic                       cfg_err,
    output logic                       busy,
    input  logic                       cnt_clr,
    output logic [CNT_W-1:0]           cnt_eval,
    output logic [CNT_W-1:0]           cnt_sat
);

    localparam int IW = $clog2(NUM_CH);
    localparam logic [IW:0] NCH = (IW+1)'(NUM_CH);

    logic [2:0]          r_op [NUM_CH];
    logic [W-1:0]        r_k  [NUM_CH];
    logic [W:0]          r_c  [NUM_CH];
    logic                r_s1_valid;
    logic [NUM_CH-1:0]   r_s1_mask;
    logic                r_s2_valid;
    logic [NUM_CH-1:0]   r_s2_mask;
    logic                r_s2_sat;
    logic                r_cfg_err;
    logic [CNT_W-1:0]    r_cnt_eval;
    logic [CNT_W-1:0]    r_cnt_sat;

    logic                w_s2_adv;
    logic                w_s1_adv;
    logic                w_in_hs;
    logic                w_out_hs;
    logic                w_cfg_ok;
    logic [NUM_CH-1:0]   w_mask;

    function automatic logic ch_eval(
        input logic [2:0]   op,
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic [W-1:0] k,
        input logic [W:0]   c
    );
        logic [2*W-1:0] prod;
        logic [W:0]     sum;
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        sum  = {1'b0, a} + {1'b0, k};
        case (op)
            3'd0:    ch_eval = |a;
            3'd1:    ch_eval = |prod;
            3'd2:    ch_eval = (sum != c);
            3'd3:    ch_eval = ({{(W-1){1'b0}}, (a == '0)} != b);
            3'd4:    ch_eval = 1'b1;
            default: ch_eval = 1'b0;
        endcase
    endfunction

    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign w_in_hs   = in_valid && w_s1_adv;
    assign w_out_hs  = r_s2_valid && out_ready;
    assign busy      = r_s1_valid || r_s2_valid;
    assign w_cfg_ok  = cfg_we && !busy && ({1'b0, cfg_idx} < NCH);

    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_valid;
    assign out_sat   = r_s2_sat;
    assign out_mask  = r_s2_mask;
    assign cfg_err   = r_cfg_err;
    assign cnt_eval  = r_cnt_eval;
    assign cnt_sat   = r_cnt_sat;

    // A write landing with a same-cycle handshake must already steer that vector
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_cfg_ok && cfg_idx == IW'(i))
                w_mask[i] = ch_eval(cfg_op, in_a[i*W +: W], in_b[i*W +: W],
                                    cfg_k, cfg_c);
            else
                w_mask[i] = ch_eval(r_op[i], in_a[i*W +: W], in_b[i*W +: W],
                                    r_k[i], r_c[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_op[i] <= 3'd4;
                r_k[i]  <= '0;
                r_c[i]  <= '0;
            end
            r_cfg_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_cfg_ok && cfg_idx == IW'(i)) begin
                    r_op[i] <= cfg_op;
                    r_k[i]  <= cfg_k;
                    r_c[i]  <= cfg_c;
                end
            end
            r_cfg_err <= cfg_we && !w_cfg_ok;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_mask  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_mask  <= '0;
            r_s2_sat   <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid)
                    r_s1_mask <= w_mask;
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_mask <= r_s1_mask;
                    r_s2_sat  <= &r_s1_mask;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_eval <= '0;
            r_cnt_sat  <= '0;
        end else if (cnt_clr) begin
            r_cnt_eval <= '0;
            r_cnt_sat  <= '0;
        end else if (w_out_hs) begin
            if (r_cnt_eval != '1)
                r_cnt_eval <= r_cnt_eval + CNT_W'(1);
            if (r_s2_sat && r_cnt_sat != '1)
                r_cnt_sat <= r_cnt_sat + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_constraint_eval_pipe.sv
// Randomised + directed bench for constraint_eval_pipe against a
// queue-based reference model of the channel rules and pipeline occupancy.
module tb_constraint_eval_pipe;

    localparam int NCH = 5;
    localparam int W   = 8;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [NCH*W-1:0] in_a;
    logic [NCH*W-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic            out_sat;
    logic [NCH-1:0]  out_mask;
    logic            cfg_we;
    logic [2:0]      cfg_idx;
    logic [2:0]      cfg_op;
    logic [W-1:0]    cfg_k;
    logic [W:0]      cfg_c;
    logic            cfg_err;
    logic            busy;
    logic            cnt_clr;
    logic [CW-1:0]   cnt_eval;
    logic [CW-1:0]   cnt_sat;

    constraint_eval_pipe #(.NUM_CH(NCH), .W(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sat(out_sat), .out_mask(out_mask),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_op(cfg_op),
        .cfg_k(cfg_k), .cfg_c(cfg_c), .cfg_err(cfg_err),
        .busy(busy), .cnt_clr(cnt_clr),
        .cnt_eval(cnt_eval), .cnt_sat(cnt_sat)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int mask;
        bit st2;
    } ent_t;

    int   m_op [NCH];
    int   m_k  [NCH];
    int   m_c  [NCH];
    ent_t q [$];
    int   m_eval;
    int   m_sat;
    bit   m_err;

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_op[i] = 4;
            m_k[i]  = 0;
            m_c[i]  = 0;
        end
        q.delete();
        m_eval = 0;
        m_sat  = 0;
        m_err  = 1'b0;
    endtask

    function automatic int meval(input logic [NCH*W-1:0] a,
                                 input logic [NCH*W-1:0] b);
        int m;
        int av;
        int bv;
        bit r;
        m = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            av = int'(a[ch*W +: W]);
            bv = int'(b[ch*W +: W]);
            case (m_op[ch])
                0: r = (av != 0);
                1: r = ((av * bv) != 0);
                2: r = ((av + m_k[ch]) != m_c[ch]);
                3: r = (((av == 0) ? 1 : 0) != bv);
                4: r = 1'b1;
                default: r = 1'b0;
            endcase
            if (r) m = m | (1 << ch);
        end
        return m;
    endfunction

    function automatic logic [NCH*W-1:0] rv();
        return (NCH*W)'({$urandom(), $urandom()});
    endfunction

    // One clock cycle: inputs are already applied at the falling edge
    task automatic cyc();
        bit   rdy;
        bit   ov;
        bit   ohs;
        bit   ihs;
        bit   ok;
        ent_t t;
        #1;
        rdy = (q.size() < 2) || out_ready;
        ov  = (q.size() > 0) && q[0].st2;
        chk("in_ready", in_ready, rdy);
        chk("out_valid", out_valid, ov);
        chk("busy", busy, q.size() > 0);
        chk("cfg_err", cfg_err, m_err);
        chk("cnt_eval", cnt_eval, m_eval);
        chk("cnt_sat", cnt_sat, m_sat);
        if (ov) begin
            chk("out_mask", out_mask, q[0].mask);
            chk("out_sat", out_sat, q[0].mask == (1 << NCH) - 1);
        end
        ohs = ov && out_ready;
        ihs = in_valid && rdy;
        ok  = cfg_we && (q.size() == 0) && (cfg_idx < NCH);
        m_err = cfg_we && !ok;
        if (cnt_clr) begin
            m_eval = 0;
            m_sat  = 0;
        end else if (ohs) begin
            if (m_eval < CMAX) m_eval++;
            if (q[0].mask == (1 << NCH) - 1 && m_sat < CMAX) m_sat++;
        end
        if (ohs) void'(q.pop_front());
        if (q.size() > 0 && !q[0].st2) begin
            t = q[0];
            t.st2 = 1'b1;
            q[0] = t;
        end
        if (ok) begin
            m_op[cfg_idx] = int'(cfg_op);
            m_k[cfg_idx]  = int'(cfg_k);
            m_c[cfg_idx]  = int'(cfg_c);
        end
        if (ihs) begin
            t.mask = meval(in_a, in_b);
            t.st2  = 1'b0;
            q.push_back(t);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic vec(input bit v, input logic [NCH*W-1:0] a,
                       input logic [NCH*W-1:0] b, input bit ordy);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        cfg_we    = 1'b0;
        cnt_clr   = 1'b0;
        cyc();
    endtask

    task automatic idle(input int n);
        repeat (n) vec(1'b0, rv(), rv(), 1'b1);
    endtask

    task automatic cfgw(input int idx, input int op, input int k, input int c);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        cfg_we    = 1'b1;
        cfg_idx   = idx[2:0];
        cfg_op    = op[2:0];
        cfg_k     = k[W-1:0];
        cfg_c     = c[W:0];
        cyc();
        cfg_we    = 1'b0;
    endtask

    task automatic clr();
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        cnt_clr  = 1'b1;
        cyc();
        cnt_clr  = 1'b0;
    endtask

    task automatic mid_rst();
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_cnt_eval", cnt_eval, 0);
        chk("rst_cnt_sat", cnt_sat, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_idx = '0; cfg_op = '0; cfg_k = '0; cfg_c = '0;
        cnt_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // single vector through default PASS config
        vec(1'b1, rv(), rv(), 1'b1);
        idle(3);

        // directed channel configuration
        cfgw(0, 1, 0, 0);
        cfgw(1, 2, 'h0D, 'h009);
        cfgw(2, 2, 'h0C, 'h054);
        cfgw(3, 3, 0, 0);
        cfgw(4, 0, 0, 0);
        vec(1'b1, {8'h11, 8'h00, 8'h00, 8'hFC, 8'h03}, 40'h0, 1'b1);
        vec(1'b1, {8'h00, 8'h05, 8'h48, 8'h09, 8'h02}, 40'h0000000107, 1'b1);
        vec(1'b1, {8'hFF, 8'h00, 8'h48, 8'hFC, 8'h02}, 40'h0001000001, 1'b1);
        idle(3);

        // backpressure
        clr();
        vec(1'b1, rv(), rv(), 1'b0);
        vec(1'b1, rv(), rv(), 1'b0);
        vec(1'b1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 40'h0, 1'b0);
        vec(1'b1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 40'h0, 1'b0);
        vec(1'b1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 40'h0, 1'b1);
        idle(4);

        // rejected writes: bad index, then while busy
        cfgw(5, 4, 0, 0);
        idle(1);
        cfgw(7, 4, 0, 0);
        idle(1);
        vec(1'b1, rv(), rv(), 1'b1);
        cfgw(0, 4, 0, 0);
        idle(3);
        vec(1'b1, {8'h01, 8'h00, 8'h00, 8'hFC, 8'h00}, 40'h0, 1'b1);
        idle(3);

        // write and handshake together
        in_valid = 1'b1; in_a = {8'h01, 8'h00, 8'h00, 8'hFC, 8'h00};
        in_b = 40'h0; out_ready = 1'b1; cnt_clr = 1'b0;
        cfg_we = 1'b1; cfg_idx = 3'd0; cfg_op = 3'd4; cfg_k = '0; cfg_c = '0;
        cyc();
        cfg_we = 1'b0;
        idle(3);

        // counter saturation and clear racing a handshake
        for (int i = 0; i < NCH; i++) cfgw(i, 4, 0, 0);
        clr();
        repeat (17) vec(1'b1, rv(), rv(), 1'b1);
        idle(3);
        vec(1'b1, rv(), rv(), 1'b1);
        vec(1'b1, rv(), rv(), 1'b1);
        cnt_clr = 1'b1;
        in_valid = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        idle(3);

        // reset with two vectors in flight
        vec(1'b1, rv(), rv(), 1'b0);
        vec(1'b1, rv(), rv(), 1'b0);
        mid_rst();
        idle(4);

        // random traffic
        for (int n = 0; n < 800; n++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_a      = rv();
            in_b      = ($urandom_range(3) == 0) ? '0 : rv();
            out_ready = ($urandom_range(2) != 0);
            cnt_clr   = ($urandom_range(31) == 0);
            cfg_we    = ($urandom_range(5) == 0);
            cfg_idx   = 3'($urandom_range(7));
            cfg_op    = 3'($urandom_range(7));
            cfg_k     = W'($urandom());
            cfg_c     = (W+1)'($urandom());
            cyc();
        end
        cfg_we = 1'b0;
        cnt_clr = 1'b0;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
